spi_slave_mem: RTL and testbench
================================

Name: spi_slave_mem

Overview:
- SPI responder that emulates a small serial memory device, i.e. the far end of the Wishbone-to-SPI master bridge.
- Implements the same four-command set as the bridge: READ 0x03, WRITE 0x02, RDSR 0x05, WREN 0x06.
- Uses a 24-bit address, SPI mode 3 (SCK idles high, sample on rising edge, shift on falling edge), MSB first.
- Serves as the on-chip loopback target for bridge bring-up and as the bench memory model. A host port gives read access to the memory contents.

Parameters:
- ADDRESS_WIDTH, 24, SPI address width in bits; must be a multiple of 8 (number of address bytes = ADDRESS_WIDTH/8).
- MEM_ADDR_BITS, 10, log2 of the internal byte-memory depth (1 KiB default); SPI address taken modulo 2**MEM_ADDR_BITS.
- MISO_IDLE, 1'b0, level driven on spi_miso while spi_ss is high.

Ports:
- clock  in  1  system clock; SPI inputs are oversampled on this clock.
- reset  in  1  synchronous, active-high reset.
- spi_sck  in  1  serial clock from the master; asynchronous to clock.
- spi_ss  in  1  active-low select; asynchronous to clock.
- spi_mosi  in  1  serial data from the master.
- spi_miso  out  1  serial data to the master.
- host_addr  in  MEM_ADDR_BITS  backdoor read address.
- host_rd_data  out  8  mem[host_addr], registered, 1-cycle latency.
- wel  out  1  write-enable latch state.
- cmd_done  out  1  one-cycle pulse when spi_ss rises after a recognised command.

Behaviour:
- Input synchronisation:
  - spi_sck, spi_ss and spi_mosi each pass through a 2-FF synchroniser plus one history FF.
  - Edges are detected on the synchronised signals (sck_rise, sck_fall, ss_fall, ss_rise).
  - Requirement on the master: SCK high and low phases each ≥ 4 clock periods; SS setup to first SCK fall ≥ 4 clock periods.
- Reset values: spi_miso=MISO_IDLE, wel=0, cmd_done=0, host_rd_data=0, FSM=IDLE, bit counter=0. Memory contents are not reset.
- Bit engine:
  - On sck_rise with SS low: shift mosi into rx_shift, increment the 3-bit bit_cnt.
  - When bit_cnt wraps 7→0, a byte is complete: byte_valid pulses for one cycle and the FSM acts on that byte.
  - On sck_fall with SS low: tx_shift shifts left; spi_miso = tx_shift[7].
- FSM states: IDLE, CMD, ADDR, WRITE_DATA, READ_DATA, STATUS, IGNORE.
  - IDLE: on ss_fall → CMD; bit_cnt=0, addr byte counter=0.
  - CMD: opcode byte decodes as
    - 0x06 → set wel, then IGNORE.
    - 0x05 → STATUS; load tx_shift = {6'b0, wel, 1'b0}, where bit0 = WIP and is always 0.
    - 0x03 / 0x02 → ADDR.
    - any other opcode → IGNORE.
  - ADDR: shift each byte into addr_reg, MSB byte first. After the last address byte: READ → READ_DATA, WRITE → WRITE_DATA.
  - READ_DATA:
    - On entry, and on every completed byte, fetch mem[addr] (1-cycle RAM latency), load tx_shift, then increment addr.
    - The load must complete before the next sck_fall so bit7 is on MISO ahead of the first sampling rising edge.
    - The status byte is loaded the same way.
  - WRITE_DATA: on each complete byte, if wel=1 write mem[addr]=rx byte and increment addr; if wel=0, discard the byte and leave addr unchanged.
  - STATUS: reload the status byte on each completed byte (continuous polling), reflecting the current wel.
  - IGNORE: discard traffic; MISO holds the last value.
- Address arithmetic: addr increments by 1 and wraps within the 2**MEM_ADDR_BITS window. Upper SPI address bits are ignored.
- ss_rise in any state: go to IDLE the next cycle, discard any partial byte, set spi_miso=MISO_IDLE, pulse cmd_done if the opcode was recognised.
  - If the command was WRITE and all address bytes were received, clear wel on ss_rise (whether or not data was written).
  - WREN followed by SS high leaves wel=1.
- Simultaneous events: ss_rise takes priority over byte_valid in the same cycle, so that byte is dropped. A host_addr read concurrent with an SPI write to the same location returns the old data.
- reset asserted mid-transfer: FSM returns to IDLE and wel clears. The ongoing transaction is ignored until the next ss_fall.

Decomposition:
- Package spi_mem_pkg holds:
  - opcode constants (CMD_READ_DATA=8'h03, CMD_WRITE_DATA=8'h02, CMD_READ_STATUS=8'h05, CMD_WRITE_ENABLE=8'h06), shared with the master bridge;
  - the FSM state encoding;
  - the status bit positions (WIP=0, WEL=1).
- One sub-module, spi_slave_sync_edge: synchroniser plus edge detector for sck/ss/mosi.
- The memory is an inferred dual-port byte RAM inside the top module.

Test Plan:
- WREN (0x06), SS high, then RDSR (0x05) with two dummy bytes → MISO returns 0x02, 0x02; wel=1; cmd_done pulses twice (once per command).
- WREN; WRITE 0x02 addr 0x000010 data 0xA5,0x5A; SS high → host_addr 0x10/0x11 read 0xA5/0x5A; wel=0 afterwards.
- WRITE without prior WREN, addr 0x20 data 0xFF → mem[0x20] unchanged (preloaded 0x00 stays 0x00); wel=0.
- READ 0x03 addr 0x0003FF, 3 data bytes, mem[0x3FF]=0x11, mem[0x000]=0x22, mem[0x001]=0x33 → MISO bytes 0x11, 0x22, 0x33 (wrap).
- READ with SS raised after 4 data bits, then RDSR → first transfer aborts cleanly; RDSR returns 0x00 with correct bit alignment.
- Opcode 0x9F followed by 3 bytes → no memory change, wel unchanged, no cmd_done pulse. Reset asserted mid-WRITE data byte → wel=0, next transaction decodes normally.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI serial-memory responder and its master bridge.
// Latency: n/a (constants, types and one helper function only).
// Backpressure: n/a.
package spi_mem_pkg;

    // Opcode set understood by both ends of the link
    localparam logic [7:0] CMD_READ_DATA    = 8'h03;
    localparam logic [7:0] CMD_WRITE_DATA   = 8'h02;
    localparam logic [7:0] CMD_READ_STATUS  = 8'h05;
    localparam logic [7:0] CMD_WRITE_ENABLE = 8'h06;

    // Status register bit positions
    localparam int STATUS_WIP_BIT = 0;
    localparam int STATUS_WEL_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WRITE_DATA,
        ST_READ_DATA,
        ST_STATUS,
        ST_IGNORE
    } state_t;

    // Status byte as returned by RDSR; this device never reports a write in progress.
    function automatic logic [7:0] status_byte(input logic wel);
        logic [7:0] s;
        s                 = 8'h00;
        s[STATUS_WEL_BIT] = wel;
        s[STATUS_WIP_BIT] = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Synchronises SCK/SS/MOSI into the system clock domain and flags SCK/SS edges.
// Latency: 2 cycles to the synchronised level, edges flagged on the cycle the level changes.
// Backpressure: none; the master must keep each SCK phase at least 4 system clocks long.
//
// Ports:
//   i_clock                  system clock
//   i_sck, i_ss, i_mosi      raw asynchronous SPI inputs
//   o_ss                     synchronised select level (active low)
//   o_mosi                   synchronised data, aligned to the history stage
//   o_sck_rise, o_sck_fall   single-cycle SCK edge strobes
//   o_ss_fall, o_ss_rise     single-cycle SS edge strobes
module spi_slave_sync_edge (
    input  logic i_clock,
    input  logic i_sck,
    input  logic i_ss,
    input  logic i_mosi,
    output logic o_ss,
    output logic o_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_ss_fall,
    output logic o_ss_rise
);

    // Bit 0 = sck, bit 1 = ss, bit 2 = mosi.
    // The chain is deliberately not reset: if it were forced to idle levels, a select
    // held low across reset release would look like a fresh SS fall and the responder
    // would start decoding in the middle of someone else's transaction.
    logic [2:0] r_meta;
    logic [2:0] r_sync;
    logic [2:0] r_hist;

    always_ff @(posedge i_clock) begin
        r_meta <= {i_mosi, i_ss, i_sck};
        r_sync <= r_meta;
        r_hist <= r_sync;
    end

    assign o_ss       = r_sync[1];
    // MOSI is stable for many cycles around the sampling SCK edge, so taking it one
    // stage later is harmless and keeps all three inputs on equal-depth paths.
    assign o_mosi     = r_hist[2];
    assign o_sck_rise =  r_sync[0] & ~r_hist[0];
    assign o_sck_fall = ~r_sync[0] &  r_hist[0];
    assign o_ss_fall  = ~r_sync[1] &  r_hist[1];
    assign o_ss_rise  =  r_sync[1] & ~r_hist[1];

endmodule

// File: rtl/spi_slave_mem.sv
// SPI mode-3 responder emulating a small serial byte memory (READ/WRITE/RDSR/WREN).
// Latency: read data is on MISO by the first SCK fall after the address/data byte; host read 1 cycle.
// Backpressure: none; SPI is master-paced, SCK phases must each last at least 4 clocks.
//
// Ports:
//   i_clock, i_reset        system clock, synchronous active-high reset
//   i_spi_sck/ss/mosi       SPI inputs from the master (asynchronous)
//   o_spi_miso              SPI data to the master
//   i_host_addr             backdoor read address
//   o_host_rd_data          mem[i_host_addr], registered
//   o_wel                   write-enable latch
//   o_cmd_done              one-cycle pulse on SS release after a recognised opcode
module spi_slave_mem
    import spi_mem_pkg::*;
#(
    parameter int   ADDRESS_WIDTH = 24,
    parameter int   MEM_ADDR_BITS = 10,
    parameter logic MISO_IDLE     = 1'b0
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_spi_sck,
    input  logic                     i_spi_ss,
    input  logic                     i_spi_mosi,
    output logic                     o_spi_miso,
    input  logic [MEM_ADDR_BITS-1:0] i_host_addr,
    output logic [7:0]               o_host_rd_data,
    output logic                     o_wel,
    output logic                     o_cmd_done
);

    localparam int ADDR_BYTES = ADDRESS_WIDTH / 8;
    localparam int ACW        = $clog2(ADDR_BYTES) + 1;
    localparam int MEM_DEPTH  = 1 << MEM_ADDR_BITS;
    localparam logic [ACW-1:0] LAST_ADDR_BYTE = ACW'(ADDR_BYTES - 1);

    // Synchronised inputs
    logic w_ss, w_mosi, w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise;

    spi_slave_sync_edge u_sync (
        .i_clock    (i_clock),
        .i_sck      (i_spi_sck),
        .i_ss       (i_spi_ss),
        .i_mosi     (i_spi_mosi),
        .o_ss       (w_ss),
        .o_mosi     (w_mosi),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_ss_fall  (w_ss_fall),
        .o_ss_rise  (w_ss_rise)
    );

    // ---------------- bit engine ----------------
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_shift;
    logic [7:0] w_rx_byte;
    logic       w_byte_vld;

    assign w_rx_byte  = {r_rx_shift, w_mosi};
    assign w_byte_vld = w_sck_rise & ~w_ss & (r_bit_cnt == 3'd7);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 7'd0;
        end else if (w_ss_fall || w_ss_rise) begin
            r_bit_cnt  <= 3'd0;
        end else if (w_sck_rise && !w_ss) begin
            r_rx_shift <= w_rx_byte[6:0];
            r_bit_cnt  <= r_bit_cnt + 3'd1;
        end
    end

    // ---------------- command FSM ----------------
    state_t                   r_state, w_state_nxt;
    logic                     r_wel, w_wel_nxt;
    logic [MEM_ADDR_BITS-1:0] r_addr, w_addr_nxt;
    logic [ACW-1:0]           r_addr_cnt, w_addr_cnt_nxt;
    logic                     r_is_read, w_is_read_nxt;
    logic                     r_is_write, w_is_write_nxt;
    logic                     r_cmd_ok, w_cmd_ok_nxt;
    logic                     r_addr_full, w_addr_full_nxt;
    logic                     r_cmd_done, w_cmd_done_nxt;
    logic                     w_mem_we, w_fetch, w_status_load, w_tx_clear;

    // Read fetch pipeline: s1 = address settled, s2 = RAM data valid (load + increment)
    logic                     r_fetch_s1, r_fetch_s2;
    logic [7:0]               r_ram_q;

    always_comb begin
        w_state_nxt     = r_state;
        w_wel_nxt       = r_wel;
        w_addr_nxt      = r_fetch_s2 ? r_addr + MEM_ADDR_BITS'(1) : r_addr;
        w_addr_cnt_nxt  = r_addr_cnt;
        w_is_read_nxt   = r_is_read;
        w_is_write_nxt  = r_is_write;
        w_cmd_ok_nxt    = r_cmd_ok;
        w_addr_full_nxt = r_addr_full;
        w_cmd_done_nxt  = 1'b0;
        w_mem_we        = 1'b0;
        w_fetch         = 1'b0;
        w_status_load   = 1'b0;
        w_tx_clear      = 1'b0;

        // SS release wins over a byte completing in the same cycle
        if (w_ss_rise) begin
            w_state_nxt    = ST_IDLE;
            w_cmd_done_nxt = r_cmd_ok;
            w_cmd_ok_nxt   = 1'b0;
            // A write command consumes the latch once its address is complete,
            // even if no data byte followed.
            if (r_is_write && r_addr_full) begin
                w_wel_nxt = 1'b0;
            end
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        w_state_nxt     = ST_CMD;
                        w_addr_cnt_nxt  = '0;
                        w_is_read_nxt   = 1'b0;
                        w_is_write_nxt  = 1'b0;
                        w_cmd_ok_nxt    = 1'b0;
                        w_addr_full_nxt = 1'b0;
                        w_tx_clear      = 1'b1;
                    end
                end
                ST_CMD: begin
                    if (w_byte_vld) begin
                        case (w_rx_byte)
                            CMD_WRITE_ENABLE: begin
                                w_wel_nxt    = 1'b1;
                                w_cmd_ok_nxt = 1'b1;
                                w_state_nxt  = ST_IGNORE;
                            end
                            CMD_READ_STATUS: begin
                                w_status_load = 1'b1;
                                w_cmd_ok_nxt  = 1'b1;
                                w_state_nxt   = ST_STATUS;
                            end
                            CMD_READ_DATA: begin
                                w_is_read_nxt = 1'b1;
                                w_cmd_ok_nxt  = 1'b1;
                                w_state_nxt   = ST_ADDR;
                            end
                            CMD_WRITE_DATA: begin
                                w_is_write_nxt = 1'b1;
                                w_cmd_ok_nxt   = 1'b1;
                                w_state_nxt    = ST_ADDR;
                            end
                            default: w_state_nxt = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (w_byte_vld) begin
                        // Only the low MEM_ADDR_BITS survive the shift: modulo addressing
                        w_addr_nxt     = MEM_ADDR_BITS'({r_addr, w_rx_byte});
                        w_addr_cnt_nxt = r_addr_cnt + ACW'(1);
                        if (r_addr_cnt == LAST_ADDR_BYTE) begin
                            w_addr_full_nxt = 1'b1;
                            if (r_is_read) begin
                                w_state_nxt = ST_READ_DATA;
                                w_fetch     = 1'b1;
                            end else begin
                                w_state_nxt = ST_WRITE_DATA;
                            end
                        end
                    end
                end
                ST_WRITE_DATA: begin
                    if (w_byte_vld && r_wel) begin
                        w_mem_we   = 1'b1;
                        w_addr_nxt = r_addr + MEM_ADDR_BITS'(1);
                    end
                end
                ST_READ_DATA: begin
                    if (w_byte_vld) begin
                        w_fetch = 1'b1;
                    end
                end
                ST_STATUS: begin
                    if (w_byte_vld) begin
                        w_status_load = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_wel       <= 1'b0;
            r_addr      <= '0;
            r_addr_cnt  <= '0;
            r_is_read   <= 1'b0;
            r_is_write  <= 1'b0;
            r_cmd_ok    <= 1'b0;
            r_addr_full <= 1'b0;
            r_cmd_done  <= 1'b0;
            r_fetch_s1  <= 1'b0;
            r_fetch_s2  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wel       <= w_wel_nxt;
            r_addr      <= w_addr_nxt;
            r_addr_cnt  <= w_addr_cnt_nxt;
            r_is_read   <= w_is_read_nxt;
            r_is_write  <= w_is_write_nxt;
            r_cmd_ok    <= w_cmd_ok_nxt;
            r_addr_full <= w_addr_full_nxt;
            r_cmd_done  <= w_cmd_done_nxt;
            r_fetch_s1  <= w_fetch;
            r_fetch_s2  <= r_fetch_s1 & ~w_ss_rise;
        end
    end

    // ---------------- transmit path ----------------
    logic [7:0] r_tx_shift;
    logic       r_miso;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tx_shift <= 8'h00;
            r_miso     <= MISO_IDLE;
        end else if (w_ss_rise) begin
            r_miso     <= MISO_IDLE;
        end else if (w_tx_clear) begin
            r_tx_shift <= 8'h00;
        end else if (w_status_load) begin
            r_tx_shift <= status_byte(r_wel);
        end else if (r_fetch_s2) begin
            r_tx_shift <= r_ram_q;
        end else if (w_sck_fall && !w_ss && r_state != ST_IGNORE && r_state != ST_IDLE) begin
            // Bit 7 goes out on the fall, ahead of the master's sampling rise
            r_miso     <= r_tx_shift[7];
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        end
    end

    // ---------------- byte memory ----------------
    logic [7:0] r_mem [MEM_DEPTH];
    logic [7:0] r_host_rd_data;

    // Reads are registered before the write lands, so a colliding read sees old data.
    always_ff @(posedge i_clock) begin
        if (w_mem_we && !i_reset) begin
            r_mem[r_addr] <= w_rx_byte;
        end
        r_ram_q <= r_mem[r_addr];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_host_rd_data <= 8'h00;
        end else begin
            r_host_rd_data <= r_mem[i_host_addr];
        end
    end

    assign o_spi_miso     = r_miso;
    assign o_host_rd_data = r_host_rd_data;
    assign o_wel          = r_wel;
    assign o_cmd_done     = r_cmd_done;

endmodule

// File: tb/tb_spi_slave_mem.sv
`timescale 1ns/1ps
module tb_spi_slave_mem;

    localparam int MAB  = 10;
    localparam int HALF = 8;   // system clocks per SCK phase

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           sck   = 1'b1;
    logic           ss    = 1'b1;
    logic           mosi  = 1'b0;
    logic           miso;
    logic [MAB-1:0] host_addr = '0;
    logic [7:0]     host_rd_data;
    logic           wel;
    logic           cmd_done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    spi_slave_mem #(
        .ADDRESS_WIDTH (24),
        .MEM_ADDR_BITS (MAB),
        .MISO_IDLE     (1'b0)
    ) dut (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_spi_sck      (sck),
        .i_spi_ss       (ss),
        .i_spi_mosi     (mosi),
        .o_spi_miso     (miso),
        .i_host_addr    (host_addr),
        .o_host_rd_data (host_rd_data),
        .o_wel          (wel),
        .o_cmd_done     (cmd_done)
    );

    always @(negedge clock) begin
        if (!reset && cmd_done === 1'b1) done_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Mode 3: drive MOSI on the fall, sample MISO on the rise, MSB first
    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sck  = 1'b0;
            mosi = tx[7-i];
            wait_clk(HALF);
            sck  = 1'b1;
            rx   = {rx[6:0], miso};
            wait_clk(HALF);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input bit chk, input string name);
        logic [7:0] rx;
        logic [7:0] exp;
        spi_bits(tx, 8, rx);
        if (chk) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s: miso byte 0x%02h but no expected byte queued", name, rx);
            end else begin
                exp = exp_q.pop_front();
                if (rx !== exp) begin
                    n_fail++;
                    $display("FAIL %s: miso byte 0x%02h, expected 0x%02h", name, rx, exp);
                end
            end
        end
    endtask

    task automatic ss_low;
        ss = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic ss_high;
        ss = 1'b1;
        wait_clk(12);
    endtask

    task automatic send_addr(input logic [23:0] a);
        spi_byte(a[23:16], 1'b0, "");
        spi_byte(a[15:8],  1'b0, "");
        spi_byte(a[7:0],   1'b0, "");
    endtask

    task automatic wren;
        ss_low();
        spi_byte(8'h06, 1'b0, "");
        ss_high();
    endtask

    // Sends n data bytes, right-aligned in d, most significant first
    task automatic write_mem(input logic [23:0] a, input logic [23:0] d, input int n);
        ss_low();
        spi_byte(8'h02, 1'b0, "");
        send_addr(a);
        for (int k = 0; k < n; k++) spi_byte(d[8*(n-1-k) +: 8], 1'b0, "");
        ss_high();
    endtask

    task automatic host_read(input logic [MAB-1:0] a, output logic [7:0] d);
        host_addr = a;
        wait_clk(2);
        d = host_rd_data;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_clk(5);
        n_checks += 4;
        if (miso !== 1'b0)         begin n_fail++; $display("FAIL reset_miso: got %b, expected 0", miso); end
        if (wel !== 1'b0)          begin n_fail++; $display("FAIL reset_wel: got %b, expected 0", wel); end
        if (cmd_done !== 1'b0)     begin n_fail++; $display("FAIL reset_cmd_done: got %b, expected 0", cmd_done); end
        if (host_rd_data !== 8'h0) begin n_fail++; $display("FAIL reset_host_rd: got 0x%02h, expected 0x00", host_rd_data); end
        reset = 1'b0;
        wait_clk(5);
    endtask

    task automatic test_wren_rdsr;
        int d0;
        d0 = done_cnt;
        wren();
        ss_low();
        spi_byte(8'h05, 1'b0, "");
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h02);
        spi_byte(8'h00, 1'b1, "rdsr_byte0");
        spi_byte(8'h00, 1'b1, "rdsr_byte1");
        ss_high();
        n_checks += 2;
        if (wel !== 1'b1) begin n_fail++; $display("FAIL wren_wel: got %b, expected 1", wel); end
        if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL wren_rdsr_done: got %0d pulses, expected 2", done_cnt - d0); end
    endtask

    task automatic test_write;
        logic [7:0] d;
        int d0;
        d0 = done_cnt;
        wren();
        write_mem(24'h000010, 24'h00A55A, 2);
        n_checks += 4;
        host_read(10'h010, d);
        if (d !== 8'hA5) begin n_fail++; $display("FAIL write_mem10: got 0x%02h, expected 0xa5", d); end
        host_read(10'h011, d);
        if (d !== 8'h5A) begin n_fail++; $display("FAIL write_mem11: got 0x%02h, expected 0x5a", d); end
        if (wel !== 1'b0) begin n_fail++; $display("FAIL write_wel_clear: got %b, expected 0", wel); end
        if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL write_done: got %0d pulses, expected 2", done_cnt - d0); end
    endtask

    task automatic test_write_protected;
        logic [7:0] d;
        wren();
        write_mem(24'h000020, 24'h000000, 1);
        write_mem(24'h000020, 24'h0000FF, 1);
        n_checks += 2;
        host_read(10'h020, d);
        if (d !== 8'h00) begin n_fail++; $display("FAIL protect_mem20: got 0x%02h, expected 0x00", d); end
        if (wel !== 1'b0) begin n_fail++; $display("FAIL protect_wel: got %b, expected 0", wel); end
    endtask

    task automatic test_read_wrap;
        logic [7:0] d;
        wren();
        write_mem(24'h0003FF, 24'h112233, 3);
        n_checks++;
        host_read(10'h000, d);
        if (d !== 8'h22) begin n_fail++; $display("FAIL write_wrap_mem0: got 0x%02h, expected 0x22", d); end
        ss_low();
        spi_byte(8'h03, 1'b0, "");
        send_addr(24'h0003FF);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        spi_byte(8'h00, 1'b1, "read_3ff");
        spi_byte(8'h00, 1'b1, "read_000");
        spi_byte(8'h00, 1'b1, "read_001");
        ss_high();
        n_checks++;
        if (miso !== 1'b0) begin n_fail++; $display("FAIL read_miso_idle: got %b, expected 0", miso); end
    endtask

    task automatic test_abort;
        logic [7:0] rx;
        for (int w = 0; w < 2; w++) begin
            if (w == 1) wren();
            ss_low();
            spi_byte(8'h03, 1'b0, "");
            send_addr(24'h000010);
            spi_bits(8'hFF, 4, rx);
            ss_high();
            n_checks++;
            if (miso !== 1'b0) begin n_fail++; $display("FAIL abort_miso_idle: got %b, expected 0", miso); end
            ss_low();
            spi_byte(8'h05, 1'b0, "");
            exp_q.push_back(w == 1 ? 8'h02 : 8'h00);
            spi_byte(8'h00, 1'b1, "abort_rdsr");
            ss_high();
        end
    endtask

    task automatic test_bad_opcode;
        logic [7:0] d;
        int d0;
        wren();
        d0 = done_cnt;
        ss_low();
        spi_byte(8'h9F, 1'b0, "");
        spi_byte(8'h00, 1'b0, "");
        spi_byte(8'h10, 1'b0, "");
        spi_byte(8'h77, 1'b0, "");
        ss_high();
        n_checks += 3;
        if (done_cnt != d0) begin n_fail++; $display("FAIL badop_done: got %0d pulses, expected 0", done_cnt - d0); end
        if (wel !== 1'b1) begin n_fail++; $display("FAIL badop_wel: got %b, expected 1", wel); end
        host_read(10'h010, d);
        if (d !== 8'hA5) begin n_fail++; $display("FAIL badop_mem10: got 0x%02h, expected 0xa5", d); end
    endtask

    task automatic test_reset_midwrite;
        logic [7:0] d;
        logic [7:0] rx;
        int d0;
        wren();
        write_mem(24'h000030, 24'h000000, 1);
        wren();
        d0 = done_cnt;
        ss_low();
        spi_byte(8'h02, 1'b0, "");
        send_addr(24'h000030);
        spi_bits(8'hC3, 4, rx);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(2);
        n_checks++;
        if (wel !== 1'b0) begin n_fail++; $display("FAIL midreset_wel: got %b, expected 0", wel); end
        spi_bits(8'h30, 4, rx);
        spi_byte(8'h66, 1'b0, "");
        ss_high();
        n_checks += 2;
        if (done_cnt != d0) begin n_fail++; $display("FAIL midreset_done: got %0d pulses, expected 0", done_cnt - d0); end
        host_read(10'h030, d);
        if (d !== 8'h00) begin n_fail++; $display("FAIL midreset_mem30: got 0x%02h, expected 0x00", d); end
        ss_low();
        spi_byte(8'h05, 1'b0, "");
        exp_q.push_back(8'h00);
        spi_byte(8'h00, 1'b1, "post_reset_rdsr");
        ss_high();
        n_checks++;
        if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL post_reset_done: got %0d pulses, expected 1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_wren_rdsr();
        test_write();
        test_write_protected();
        test_read_wrap();
        test_abort();
        test_bad_opcode();
        test_reset_midwrite();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected bytes never produced, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
